klein_96_sequencer: RTL and testbench

- Handshaked sequencer for the byte-serial KLEIN-96 datapath (klein_comb style).
- Accepts 8 data bytes and 12 key bytes over a valid/ready load port.
- Steps the datapath through 20 rounds plus the final key whitening.
- Streams the 8 ciphertext bytes out under receiver backpressure, and generates every datapath select, load and enable strobe.

---
 rtl/klein_pkg.sv | 18 +
 rtl/klein_seq_counter.sv | 30 +++
 rtl/klein_96_sequencer.sv | 121 ++++++++++++
 tb/tb_klein_96_sequencer.sv | 179 +++++++++++++++++
 4 files changed

// File: rtl/klein_pkg.sv
// Shared types and constants for the KLEIN-96 byte-serial sequencer.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package klein_pkg;

   typedef enum logic [2:0] {
      IDLE,
      LOAD,
      RUN,
      FIN,
      UNLOAD
   } state_t;

   localparam int KLEIN96_ROUNDS = 20;
   localparam int KLEIN_DBYTES   = 8;
   localparam int KLEIN96_KBYTES = 12;

endpackage

// File: rtl/klein_seq_counter.sv
// Modulo-N up counter with enable, synchronous clear and a wrap flag.
// Latency: count updates one clock after en; wrap is combinational on en.
// Backpressure: none; holds its value whenever en is low.
// Ports: ck/rn clock and async active-low reset; en advance; clr clear to 0
//        (wins over en); cnt current count; wrap high when en at cnt=N-1.
module klein_seq_counter #(
   parameter int N = 12,
   parameter int W = 4
) (
   input  logic         ck,
   input  logic         rn,
   input  logic         en,
   input  logic         clr,
   output logic [W-1:0] cnt,
   output logic         wrap
);

   assign wrap = en && (cnt == W'(N - 1));

   always_ff @(posedge ck or negedge rn) begin
      if (!rn) begin
         cnt <= '0;
      end else if (clr) begin
         cnt <= '0;
      end else if (en) begin
         cnt <= wrap ? '0 : cnt + W'(1);
      end
   end

endmodule

// File: rtl/klein_96_sequencer.sv
// Sequencer for the byte-serial KLEIN-96 datapath: load, 20 rounds, whitening, unload.
// Latency: start to first out_valid 261 cycles unstalled; last out beat 7 cycles later.
// Backpressure: load stalls on in_valid low, unload stalls on out_ready low; RUN/FIN never stall.
// Ports: ck/rn clock and async active-low reset; start begins a block from IDLE;
//        in_valid/in_ready load handshake; out_valid/out_ready unload handshake;
//        en/round0/round1/fin datapath strobes; round/sels/selk indices;
//        ready pulses on the final accepted out beat; busy high outside IDLE.
module klein_96_sequencer
   import klein_pkg::*;
#(
   parameter int ROUNDS = KLEIN96_ROUNDS,
   parameter int DBYTES = KLEIN_DBYTES,
   parameter int KBYTES = KLEIN96_KBYTES
) (
   input  logic       ck,
   input  logic       rn,
   input  logic       start,
   input  logic       in_valid,
   output logic       in_ready,
   output logic       out_valid,
   input  logic       out_ready,
   output logic       en,
   output logic       round0,
   output logic       round1,
   output logic       fin,
   output logic [4:0] round,
   output logic [3:0] sels,
   output logic [4:0] selk,
   output logic       ready,
   output logic       busy
);

   state_t     state;
   logic [3:0] cyc;
   logic       cyc_en;
   logic       cyc_clr;
   logic       cyc_wrap;
   logic       in_beat;
   logic       out_beat;
   logic       fin_last;
   logic       out_last;

   assign in_beat  = (state == LOAD) && in_valid;
   assign out_beat = (state == UNLOAD) && out_ready;
   assign fin_last = (state == FIN) && (cyc == 4'(DBYTES - 1));
   assign out_last = out_beat && (cyc == 4'(DBYTES - 1));

   // LOAD and RUN rely on the natural 11->0 wrap; FIN and UNLOAD end at
   // byte 7, so they force the counter back to 0 with a clear.
   assign cyc_en  = in_beat || (state == RUN) || (state == FIN) || out_beat;
   assign cyc_clr = (state == IDLE) || fin_last || out_last;

   klein_seq_counter #(
      .N (KBYTES),
      .W (4)
   ) u_cyc (
      .ck   (ck),
      .rn   (rn),
      .en   (cyc_en),
      .clr  (cyc_clr),
      .cnt  (cyc),
      .wrap (cyc_wrap)
   );

   always_ff @(posedge ck or negedge rn) begin
      if (!rn) begin
         state <= IDLE;
         round <= '0;
      end else begin
         case (state)
            IDLE: begin
               round <= '0;
               if (start) state <= LOAD;
            end
            LOAD: begin
               if (cyc_wrap) begin
                  state <= RUN;
                  round <= '0;
               end
            end
            RUN: begin
               if (cyc_wrap) begin
                  if (round == 5'(ROUNDS - 1)) begin
                     state <= FIN;
                     round <= 5'(ROUNDS);
                  end else begin
                     round <= round + 5'd1;
                  end
               end
            end
            FIN: begin
               if (fin_last) state <= UNLOAD;
            end
            UNLOAD: begin
               if (out_last) begin
                  state <= IDLE;
                  round <= '0;
               end
            end
            default: begin
               state <= IDLE;
               round <= '0;
            end
         endcase
      end
   end

   // Decode from registered state/counters; only the handshake-qualified
   // strobes (en, ready) look at the valid/ready inputs.
   assign in_ready  = (state == LOAD);
   assign out_valid = (state == UNLOAD);
   assign en        = in_beat || (state == RUN) || (state == FIN) || out_beat;
   assign round0    = (state == LOAD);
   assign round1    = (state == RUN) && (cyc == 4'd0);
   assign fin       = (state == FIN);
   assign sels      = cyc;
   assign selk      = {1'b0, cyc};
   assign ready     = out_last;
   assign busy      = (state != IDLE);

endmodule

// File: tb/tb_klein_96_sequencer.sv
// Directed self-checking bench for klein_96_sequencer.
// Latency: n/a.
// Backpressure: bench drives in_valid/out_ready patterns directly.
module tb_klein_96_sequencer;

   logic       ck;
   logic       rn;
   logic       start;
   logic       in_valid;
   logic       in_ready;
   logic       out_valid;
   logic       out_ready;
   logic       en;
   logic       round0;
   logic       round1;
   logic       fin;
   logic [4:0] round;
   logic [3:0] sels;
   logic [4:0] selk;
   logic       ready;
   logic       busy;

   int n_checks = 0;
   int n_errors = 0;

   klein_96_sequencer dut (
      .ck        (ck),
      .rn        (rn),
      .start     (start),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .en        (en),
      .round0    (round0),
      .round1    (round1),
      .fin       (fin),
      .round     (round),
      .sels      (sels),
      .selk      (selk),
      .ready     (ready),
      .busy      (busy)
   );

   initial ck = 1'b0;
   always #5 ck = ~ck;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   // Compares every output at once; layout
   // {in_ready,out_valid,en,round0,round1,fin,round,sels,selk,ready,busy}.
   task automatic outs_chk(input string tag, input logic ir, input logic ov, input logic e,
                           input logic r0, input logic r1, input logic f,
                           input logic [4:0] rnd, input logic [3:0] s,
                           input logic rdy, input logic bsy);
      logic [31:0] act;
      logic [31:0] exp;
      act = {10'd0, in_ready, out_valid, en, round0, round1, fin, round, sels, selk, ready, busy};
      exp = {10'd0, ir, ov, e, r0, r1, f, rnd, s, {1'b0, s}, rdy, bsy};
      chk(tag, act, exp);
   endtask

   task automatic idle_chk(input string tag);
      outs_chk(tag, 0, 0, 0, 0, 0, 0, 5'd0, 4'd0, 0, 0);
   endtask

   // One block from IDLE. load_stall uses in_valid 1,0,0,1,0,0...;
   // unload_stall drops out_ready for 5 cycles at byte 3. A start pulse is
   // applied mid-RUN, mid-UNLOAD and in the ready cycle. abort_at >= 0
   // drops rn during that RUN cycle and returns.
   task automatic do_block(input bit load_stall, input bit unload_stall, input int abort_at);
      int k;
      int t;
      int stalls;
      @(negedge ck);
      start = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
      #1 idle_chk("idle_start");

      k = 0; t = 0;
      while (k < 12 && t < 100) begin
         @(negedge ck);
         start    = 1'b0;
         in_valid = load_stall ? (t % 3 == 0) : 1'b1;
         #1 outs_chk("load", 1, 0, in_valid, 1, 0, 0, 5'd0, 4'(k), 0, 1);
         if (in_valid) k++;
         t++;
      end
      if (k != 12) chk("load_bound", 32'(k), 32'd12);

      for (int i = 0; i < 240; i++) begin
         @(negedge ck);
         in_valid = 1'b0;
         start    = (i == 100);
         #1 outs_chk("run", 0, 0, 1, 0, (i % 12 == 0), 0, 5'(i / 12), 4'(i % 12), 0, 1);
         if (i == abort_at) begin
            rn = 1'b0;
            #1 idle_chk("async_reset");
            return;
         end
      end

      for (int i = 0; i < 8; i++) begin
         @(negedge ck);
         start = 1'b0;
         #1 outs_chk("fin", 0, 0, 1, 0, 0, 1, 5'd20, 4'(i), 0, 1);
      end

      k = 0; stalls = 0; t = 0;
      while (k < 8 && t < 100) begin
         @(negedge ck);
         if (unload_stall && k == 3 && stalls < 5) begin
            out_ready = 1'b0;
            stalls++;
         end else begin
            out_ready = 1'b1;
         end
         start = (k == 2 || k == 7);
         #1 outs_chk("unload", 0, 1, out_ready, 0, 0, 0, 5'd20, 4'(k), out_ready && (k == 7), 1);
         if (out_ready) k++;
         t++;
      end
      if (k != 8) chk("unload_bound", 32'(k), 32'd8);
      if (unload_stall) chk("stall_count", 32'(stalls), 32'd5);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      rn = 1'b0; start = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
      #12;
      idle_chk("reset");
      @(negedge ck);
      rn = 1'b1;
      #1 idle_chk("reset_release");
      for (int i = 0; i < 3; i++) begin
         @(negedge ck);
         #1 idle_chk("idle_hold");
      end

      // Nominal block, then a back-to-back stalled block (start is held
      // through the ready cycle, so it lands in the next IDLE cycle).
      do_block(1'b0, 1'b0, -1);
      do_block(1'b1, 1'b1, -1);
      // Third block reset mid-RUN at round 7, cyc 5 (RUN cycle 89).
      do_block(1'b0, 1'b0, 89);

      @(negedge ck);
      start = 1'b0;
      #1 idle_chk("in_reset");
      @(negedge ck);
      rn = 1'b1;
      for (int i = 0; i < 4; i++) begin
         @(negedge ck);
         #1 idle_chk("post_reset_idle");
      end

      // Confirm the sequencer still starts cleanly after the abort.
      @(negedge ck);
      start = 1'b1;
      #1 idle_chk("restart_idle");
      @(negedge ck);
      start = 1'b0; in_valid = 1'b1;
      #1 outs_chk("restart_load", 1, 0, 1, 1, 0, 0, 5'd0, 4'd0, 0, 1);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
